mc_ctrl_fsm: RTL and testbench

Multicycle MIPS control unit that drives the control inputs of the multicycle datapath (IRWrite, PC/memory/ALU/register-file selects). It sits beside the datapath in the multicycle SoC top level. It takes opcode/funct/zero back from the datapath and a ready handshake from the memory-I/O bus. One instruction takes 3–5 states plus any memory wait cycles.

---
 rtl/mc_ctrl_fsm.sv | 293 +++++++++++++++++++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multicycle MIPS control unit.
// Moore FSM that steers the multicycle datapath. Outputs are registered
// (decoded from the next state). The only exception is the instruction-fetch
// completion (IRWrite / PCWrite in IF), which follows MIO_ready combinationally
// so the IR and PC load in the same cycle the memory returns the word.
// Optional feature macro: MC_CTRL_JR_EN (adds the jr instruction, state 13).
module mc_ctrl_fsm #(
   parameter logic [2:0] ADD_CODE = 3'b010,
   parameter logic [2:0] SUB_CODE = 3'b110
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] OP,
   input  logic [5:0] Fun,
   input  logic       zero,
   input  logic       MIO_ready,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IorD,
   output logic       IRWrite,
   output logic       RegWrite,
   output logic [1:0] RegDst,
   output logic [1:0] MemtoReg,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [2:0] ALU_Control,
   output logic [1:0] PCSource,
   output logic       PCWrite,
   output logic       PCWriteCond,
   output logic       Branch,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      S_IF  = 4'd0,
      S_ID  = 4'd1,
      S_MA  = 4'd2,
      S_MRD = 4'd3,
      S_MWB = 4'd4,
      S_MWR = 4'd5,
      S_REX = 4'd6,
      S_RWB = 4'd7,
      S_BR  = 4'd8,
      S_JMP = 4'd9,
      S_IEX = 4'd10,
      S_IWB = 4'd11,
      S_JAL = 4'd12,
      S_JR  = 4'd13,
      S_ERR = 4'd15
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] FUN_JR   = 6'b001000;

   state_t     state_q, state_d;

   logic       mem_read_q, mem_read_d;
   logic       mem_write_q, mem_write_d;
   logic       iord_q, iord_d;
   logic       reg_write_q, reg_write_d;
   logic [1:0] reg_dst_q, reg_dst_d;
   logic [1:0] mem_to_reg_q, mem_to_reg_d;
   logic       alu_src_a_q, alu_src_a_d;
   logic [1:0] alu_src_b_q, alu_src_b_d;
   logic [2:0] alu_ctrl_q, alu_ctrl_d;
   logic [1:0] pc_source_q, pc_source_d;
   logic       pc_write_q, pc_write_d;
   logic       pc_write_cond_q, pc_write_cond_d;
   logic       branch_q, branch_d;

   logic       fun_ok;
   logic [2:0] fun_alu;
   logic       is_jr;
   logic       if_done;

   // The zero flag is consumed by the datapath's conditional PC-load gate,
   // not by this FSM.
   logic       unused_zero;
   assign unused_zero = zero;

`ifdef MC_CTRL_JR_EN
   assign is_jr = (Fun == FUN_JR);
`else
   assign is_jr = 1'b0;
`endif

   // Fetch completes only once a read has actually been issued; this keeps the
   // first cycle after reset (outputs still cleared) from consuming MIO_ready.
   assign if_done = (state_q == S_IF) && mem_read_q && MIO_ready;

   // R-type funct decode into ALU operation and a supported flag.
   always_comb begin
      fun_ok  = 1'b1;
      fun_alu = ADD_CODE;
      case (Fun)
         6'b100000: fun_alu = ADD_CODE;
         6'b100010: fun_alu = SUB_CODE;
         6'b100100: fun_alu = 3'b000;
         6'b100101: fun_alu = 3'b001;
         6'b101010: fun_alu = 3'b111;
         6'b100111: fun_alu = 3'b100;
         6'b100110: fun_alu = 3'b011;
         6'b000010: fun_alu = 3'b101;
         default:   fun_ok  = 1'b0;
      endcase
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IF:  if (if_done) state_d = S_ID;
         S_ID: begin
            case (OP)
               OP_RTYPE:                                 state_d = is_jr ? S_JR : S_REX;
               OP_LW, OP_SW:                             state_d = S_MA;
               OP_BEQ, OP_BNE:                           state_d = S_BR;
               OP_J:                                     state_d = S_JMP;
               OP_JAL:                                   state_d = S_JAL;
               OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_LUI: state_d = S_IEX;
               default:                                  state_d = S_ERR;
            endcase
         end
         S_MA:  state_d = (OP == OP_LW) ? S_MRD : S_MWR;
         S_MRD: if (MIO_ready) state_d = S_MWB;
         S_MWB: state_d = S_IF;
         S_MWR: if (MIO_ready) state_d = S_IF;
         S_REX: state_d = fun_ok ? S_RWB : S_ERR;
         S_RWB: state_d = S_IF;
         S_BR:  state_d = S_IF;
         S_JMP: state_d = S_IF;
         S_IEX: state_d = S_IWB;
         S_IWB: state_d = S_IF;
         S_JAL: state_d = S_IF;
         S_JR:  state_d = S_IF;
         S_ERR: state_d = S_ERR;
         default: state_d = S_ERR;
      endcase
   end

   // Moore output decode of the state being entered, registered below.
   always_comb begin
      mem_read_d      = 1'b0;
      mem_write_d     = 1'b0;
      iord_d          = 1'b0;
      reg_write_d     = 1'b0;
      reg_dst_d       = 2'b00;
      mem_to_reg_d    = 2'b00;
      alu_src_a_d     = 1'b0;
      alu_src_b_d     = 2'b00;
      alu_ctrl_d      = 3'b000;
      pc_source_d     = 2'b00;
      pc_write_d      = 1'b0;
      pc_write_cond_d = 1'b0;
      branch_d        = 1'b0;
      case (state_d)
         S_IF: begin
            mem_read_d  = 1'b1;
            alu_src_b_d = 2'b01;
            alu_ctrl_d  = ADD_CODE;
         end
         S_ID: begin
            alu_src_b_d = 2'b11;
            alu_ctrl_d  = ADD_CODE;
         end
         S_MA: begin
            alu_src_a_d = 1'b1;
            alu_src_b_d = 2'b10;
            alu_ctrl_d  = ADD_CODE;
         end
         S_MRD: begin
            mem_read_d = 1'b1;
            iord_d     = 1'b1;
         end
         S_MWB: begin
            mem_to_reg_d = 2'b01;
            reg_write_d  = 1'b1;
         end
         S_MWR: begin
            mem_write_d = 1'b1;
            iord_d      = 1'b1;
         end
         S_REX: begin
            alu_src_a_d = 1'b1;
            alu_ctrl_d  = fun_alu;
         end
         S_RWB: begin
            reg_dst_d   = 2'b01;
            reg_write_d = 1'b1;
         end
         S_BR: begin
            alu_src_a_d     = 1'b1;
            alu_ctrl_d      = SUB_CODE;
            pc_write_cond_d = 1'b1;
            pc_source_d     = 2'b01;
            branch_d        = (OP == OP_BEQ);
         end
         S_JMP: begin
            pc_source_d = 2'b10;
            pc_write_d  = 1'b1;
         end
         S_IEX: begin
            alu_src_a_d = 1'b1;
            alu_src_b_d = 2'b10;
            case (OP)
               OP_ANDI: alu_ctrl_d = 3'b000;
               OP_ORI:  alu_ctrl_d = 3'b001;
               OP_SLTI: alu_ctrl_d = 3'b111;
               default: alu_ctrl_d = ADD_CODE;
            endcase
         end
         S_IWB: begin
            reg_write_d  = 1'b1;
            mem_to_reg_d = (OP == OP_LUI) ? 2'b10 : 2'b00;
         end
         S_JAL: begin
            pc_source_d  = 2'b10;
            pc_write_d   = 1'b1;
            reg_dst_d    = 2'b10;
            mem_to_reg_d = 2'b11;
            reg_write_d  = 1'b1;
         end
         S_JR: begin
            pc_source_d = 2'b11;
            pc_write_d  = 1'b1;
         end
         default: ;
      endcase
   end

   // State and output registers; reset returns to IF with all outputs cleared.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q         <= S_IF;
         mem_read_q      <= 1'b0;
         mem_write_q     <= 1'b0;
         iord_q          <= 1'b0;
         reg_write_q     <= 1'b0;
         reg_dst_q       <= 2'b00;
         mem_to_reg_q    <= 2'b00;
         alu_src_a_q     <= 1'b0;
         alu_src_b_q     <= 2'b00;
         alu_ctrl_q      <= 3'b000;
         pc_source_q     <= 2'b00;
         pc_write_q      <= 1'b0;
         pc_write_cond_q <= 1'b0;
         branch_q        <= 1'b0;
      end else begin
         state_q         <= state_d;
         mem_read_q      <= mem_read_d;
         mem_write_q     <= mem_write_d;
         iord_q          <= iord_d;
         reg_write_q     <= reg_write_d;
         reg_dst_q       <= reg_dst_d;
         mem_to_reg_q    <= mem_to_reg_d;
         alu_src_a_q     <= alu_src_a_d;
         alu_src_b_q     <= alu_src_b_d;
         alu_ctrl_q      <= alu_ctrl_d;
         pc_source_q     <= pc_source_d;
         pc_write_q      <= pc_write_d;
         pc_write_cond_q <= pc_write_cond_d;
         branch_q        <= branch_d;
      end
   end

   assign MemRead     = mem_read_q;
   assign MemWrite    = mem_write_q;
   assign IorD        = iord_q;
   assign IRWrite     = if_done;
   assign RegWrite    = reg_write_q;
   assign RegDst      = reg_dst_q;
   assign MemtoReg    = mem_to_reg_q;
   assign ALUSrcA     = alu_src_a_q;
   assign ALUSrcB     = alu_src_b_q;
   assign ALU_Control = alu_ctrl_q;
   assign PCSource    = pc_source_q;
   assign PCWrite     = pc_write_q | if_done;
   assign PCWriteCond = pc_write_cond_q;
   assign Branch      = branch_q;
   assign state       = state_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb_mc_ctrl_fsm: randomized bench for mc_ctrl_fsm. A reference model tracks
// each instruction as a list of phases (state numbers) and a position in it;
// expected outputs come from a per-phase table.
module tb_mc_ctrl_fsm;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [5:0] OP, Fun;
   logic       zero, MIO_ready;
   logic       MemRead, MemWrite, IorD, IRWrite, RegWrite;
   logic [1:0] RegDst, MemtoReg, ALUSrcB, PCSource;
   logic       ALUSrcA, PCWrite, PCWriteCond, Branch;
   logic [2:0] ALU_Control;
   logic [3:0] state;

   mc_ctrl_fsm dut (
      .clk(clk), .rst_n(rst_n), .OP(OP), .Fun(Fun), .zero(zero), .MIO_ready(MIO_ready),
      .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD), .IRWrite(IRWrite),
      .RegWrite(RegWrite), .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA),
      .ALUSrcB(ALUSrcB), .ALU_Control(ALU_Control), .PCSource(PCSource),
      .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .Branch(Branch), .state(state)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   // Phase list of one instruction; returns -1 past the end.
   function automatic int phase_at(input logic [5:0] op, input logic [5:0] fun, input int pos);
      int seq[$];
      bit rfun_ok;
      rfun_ok = (fun == 6'b100000) || (fun == 6'b100010) || (fun == 6'b100100) ||
                (fun == 6'b100101) || (fun == 6'b101010) || (fun == 6'b100111) ||
                (fun == 6'b100110) || (fun == 6'b000010);
      case (op)
         6'b000000: begin
`ifdef MC_CTRL_JR_EN
            if (fun == 6'b001000) seq = '{0, 1, 13};
            else
`endif
            if (rfun_ok) seq = '{0, 1, 6, 7};
            else         seq = '{0, 1, 6, 15};
         end
         6'b100011: seq = '{0, 1, 2, 3, 4};
         6'b101011: seq = '{0, 1, 2, 5};
         6'b000100, 6'b000101: seq = '{0, 1, 8};
         6'b000010: seq = '{0, 1, 9};
         6'b000011: seq = '{0, 1, 12};
         6'b001000, 6'b001100, 6'b001101, 6'b001010, 6'b001111: seq = '{0, 1, 10, 11};
         default: seq = '{0, 1, 15};
      endcase
      return (pos < seq.size()) ? seq[pos] : -1;
   endfunction

   // Expected output vector for a phase:
   // {MemRead,MemWrite,IorD,IRWrite,RegWrite,RegDst,MemtoReg,ALUSrcA,ALUSrcB,ALU,PCSource,PCWrite,PCWriteCond,Branch}
   function automatic logic [19:0] exp_outs(input int ph, input bit dead, input logic [5:0] op,
                                            input logic [5:0] fun, input logic rdy);
      logic mr, mw, iod, irw, rw, sa, pcw, pcc, br;
      logic [1:0] rd, m2r, sb, pcs;
      logic [2:0] alu;
      {mr, mw, iod, irw, rw, sa, pcw, pcc, br} = '0;
      {rd, m2r, sb, pcs} = '0;
      alu = 3'b000;
      if (!dead) begin
         case (ph)
            0:  begin mr = 1; sb = 2'b01; alu = 3'b010; irw = rdy; pcw = rdy; end
            1:  begin sb = 2'b11; alu = 3'b010; end
            2:  begin sa = 1; sb = 2'b10; alu = 3'b010; end
            3:  begin mr = 1; iod = 1; end
            4:  begin m2r = 2'b01; rw = 1; end
            5:  begin mw = 1; iod = 1; end
            6:  begin
               sa = 1;
               case (fun)
                  6'b100010: alu = 3'b110;
                  6'b100100: alu = 3'b000;
                  6'b100101: alu = 3'b001;
                  6'b101010: alu = 3'b111;
                  6'b100111: alu = 3'b100;
                  6'b100110: alu = 3'b011;
                  6'b000010: alu = 3'b101;
                  default:   alu = 3'b010;
               endcase
            end
            7:  begin rd = 2'b01; rw = 1; end
            8:  begin sa = 1; alu = 3'b110; pcc = 1; pcs = 2'b01; br = (op == 6'b000100); end
            9:  begin pcs = 2'b10; pcw = 1; end
            10: begin
               sa = 1; sb = 2'b10;
               alu = (op == 6'b001100) ? 3'b000 : (op == 6'b001101) ? 3'b001 :
                     (op == 6'b001010) ? 3'b111 : 3'b010;
            end
            11: begin rw = 1; m2r = (op == 6'b001111) ? 2'b10 : 2'b00; end
            12: begin pcs = 2'b10; pcw = 1; rd = 2'b10; m2r = 2'b11; rw = 1; end
            13: begin pcs = 2'b11; pcw = 1; end
            default: ;
         endcase
      end
      return {mr, mw, iod, irw, rw, rd, m2r, sa, sb, alu, pcs, pcw, pcc, br};
   endfunction

   int m_pos  = 0;
   bit m_dead = 1'b1;
   bit checking = 1'b0;

   // Reference model step at each active edge.
   always @(posedge clk) begin
      int ph, np;
      if (!rst_n) begin
         m_pos    <= 0;
         m_dead   <= 1'b1;
         checking <= 1'b1;
      end else if (checking) begin
         if (m_dead) begin
            m_dead <= 1'b0;
         end else begin
            ph = phase_at(OP, Fun, m_pos);
            np = m_pos;
            if (ph == 15) np = m_pos;
            else if ((ph == 0 || ph == 3 || ph == 5) && !MIO_ready) np = m_pos;
            else begin
               np = m_pos + 1;
               if (phase_at(OP, Fun, np) < 0) np = 0;
            end
            m_pos <= np;
         end
      end
   end

   // Compare DUT against the model away from the active edge.
   always @(negedge clk) begin
      if (checking) begin
         int ph;
         ph = m_dead ? 0 : phase_at(OP, Fun, m_pos);
         check_val("state", {28'd0, state}, ph);
         check_val("outputs",
                   {12'd0, MemRead, MemWrite, IorD, IRWrite, RegWrite, RegDst, MemtoReg,
                    ALUSrcA, ALUSrcB, ALU_Control, PCSource, PCWrite, PCWriteCond, Branch},
                   {12'd0, exp_outs(ph, m_dead, OP, Fun, MIO_ready)});
      end
   end

   localparam int NDIR = 22;
   logic [5:0] dop  [NDIR] = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h02, 6'h03, 6'h08,
                               6'h0c, 6'h0d, 6'h0a, 6'h0f, 6'h00, 6'h00, 6'h00, 6'h00,
                               6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h3f};
   logic [5:0] dfun [NDIR] = '{6'h20, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
                               6'h00, 6'h00, 6'h00, 6'h00, 6'h22, 6'h24, 6'h25, 6'h2a,
                               6'h27, 6'h26, 6'h02, 6'h08, 6'h20, 6'h00};
   logic [5:0] rop  [12]   = '{6'h00, 6'h00, 6'h00, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h02,
                               6'h03, 6'h08, 6'h0c, 6'h0f};
   logic [5:0] rfun [9]    = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h27, 6'h26, 6'h02, 6'h08};

   initial begin
      int  di;
      int  err_cycles;
      int  rst_left;
      bit  picked;
      int  ph;
      di = 0; err_cycles = 0; rst_left = 0; picked = 1'b0;
      rst_n = 1'b0; MIO_ready = 1'b1; OP = 6'h00; Fun = 6'h20; zero = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      for (int cyc = 0; cyc < 6000; cyc++) begin
         @(posedge clk);
         #1;
         zero = 1'($urandom);
         ph = m_dead ? -2 : phase_at(OP, Fun, m_pos);
         if (m_pos != 0 || m_dead) picked = 1'b0;
         err_cycles = (ph == 15) ? err_cycles + 1 : 0;
         if (rst_left > 0) begin
            rst_left--;
            rst_n = (rst_left == 0);
         end else if (err_cycles >= 12) begin
            rst_n = 1'b0; rst_left = 2; err_cycles = 0;
         end else if (di >= NDIR && ($urandom % 150) == 0) begin
            rst_n = 1'b0; rst_left = 1 + ($urandom % 2);
         end
         if (!rst_n) begin
            MIO_ready = 1'b1;
         end else begin
            if (ph == 0 && !picked) begin
               picked = 1'b1;
               if (di < NDIR) begin
                  OP = dop[di]; Fun = dfun[di]; di++;
               end else begin
                  case ($urandom % 16)
                     0:       begin OP = 6'($urandom); Fun = 6'($urandom); end
                     1:       begin OP = 6'h00; Fun = 6'($urandom); end
                     default: begin
                        OP  = rop[$urandom % 12];
                        Fun = (OP == 6'h00) ? rfun[$urandom % 9] : 6'($urandom);
                     end
                  endcase
               end
            end
            MIO_ready = (di <= NDIR) ? (($urandom % 4) != 0) : 1'($urandom);
         end
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
